// File: rtl/ins_fetch_if.sv
// Bundle of the fetch stage's memory-side (req/gnt + rvalid), decode-side (valid/ready)
// and redirect signals. The fetch unit uses the master view; the memory and decode side use slave.
interface ins_fetch_if #(
  parameter int INS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [INS_WIDTH-1:0]  imem_rdata;
  logic                  ins_valid;
  logic                  ins_ready;
  logic [INS_WIDTH-1:0]  ins;
  logic [ADDR_WIDTH-1:0] ins_pc;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, ins_valid, ins, ins_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, ins_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, ins_valid, ins, ins_pc,
    output imem_gnt, imem_rvalid, imem_rdata, ins_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches, buffers
// in-order responses with their PCs and handles redirects by flushing and dropping in-flight data.
module ins_fetch #(
  parameter int                    INS_WIDTH  = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input logic        clk,
  input logic        rst_n,
  ins_fetch_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [INS_WIDTH-1:0]  ins;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  entry_t                fifo_q [FIFO_DEPTH];
  entry_t                fifo_d [FIFO_DEPTH];
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic [CW-1:0]         outstanding_q;
  logic [CW-1:0]         drop_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] resp_pc_q;
  logic [CW:0]           credit_used;
  logic                  req;
  logic                  fire;
  logic                  rsp;
  logic                  keep;
  logic                  valid;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] target;
  logic                  unused_pc_low;

  // Buffered entries and in-flight fetches share one credit pool, so a response always has a slot.
  assign credit_used   = {1'b0, outstanding_q} + {1'b0, count_q};
  assign req           = rst_n && !bus.redirect && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign fire          = req && bus.imem_gnt;
  assign rsp           = bus.imem_rvalid && (outstanding_q != '0);
  assign keep          = rsp && (drop_q == '0) && !bus.redirect;
  assign valid         = (count_q != '0);
  assign pop           = valid && bus.ins_ready;
  assign target        = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_pc_low = ^bus.redirect_pc[1:0];

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;
  assign bus.ins_valid = valid;
  assign bus.ins       = fifo_q[0].ins;
  assign bus.ins_pc    = fifo_q[0].pc;

  // Shift-register FIFO with the head fixed at entry 0; a push lands after any same-cycle pop.
  always_comb begin
    fifo_d  = fifo_q;
    count_d = count_q;
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        fifo_d[i] = fifo_q[i+1];
      end
      count_d = count_q - CW'(1);
    end
    if (keep) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (CW'(i) == count_d) begin
          fifo_d[i] = '{ins: bus.imem_rdata, pc: resp_pc_q};
        end
      end
      count_d = count_d + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      outstanding_q <= outstanding_q + CW'(fire) - CW'(rsp);
      if (bus.redirect) begin
        // drop is the stale share of outstanding, so every fetch still in flight becomes stale.
        pc_q      <= target;
        resp_pc_q <= target;
        count_q   <= '0;
        drop_q    <= outstanding_q - CW'(rsp);
      end else begin
        if (fire) begin
          pc_q <= pc_q + ADDR_WIDTH'(4);
        end
        if (keep) begin
          resp_pc_q <= resp_pc_q + ADDR_WIDTH'(4);
        end
        if (rsp && (drop_q != '0)) begin
          drop_q <= drop_q - CW'(1);
        end
        count_q <= count_d;
        fifo_q  <= fifo_d;
      end
    end
  end

  a_no_orphan_rvalid : assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.imem_rvalid && (outstanding_q == '0)));
endmodule
